// File: rtl/serial_pkg.sv
// Shared definitions for the serial shift-register stage and its deserializer.
package serial_pkg;

    localparam int SER_WORD_W = 8;
    localparam bit LSB_FIRST  = 1'b1;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/serial_deserializer.sv
// Reassembles an LSB-first serial bit stream into n-bit words presented on a
// valid/ready output with a one-word holding register and sticky overrun flag.
module serial_deserializer
    import serial_pkg::*;
#(
    parameter int n = SER_WORD_W
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  si,
    input  logic                  en,
    input  logic                  sync,
    output logic [n-1:0]          dout,
    output logic                  dvalid,
    input  logic                  dready,
    output logic                  overrun,
    input  logic                  clr_ovr,
    output logic [clog2(n)-1:0]   bit_cnt
);

    localparam int            CW   = clog2(n);
    localparam logic [CW-1:0] LAST = CW'(n - 1);

    logic [n-1:0] asm_reg;
    logic [n-1:0] candidate;
    logic         complete;
    logic         hold_free;

    // The word formed on this edge if it turns out to be the last bit.
    assign candidate = LSB_FIRST ? {si, asm_reg[n-1:1]} : {asm_reg[n-2:0], si};
    assign complete  = en && !sync && (bit_cnt == LAST);
    assign hold_free = !dvalid || dready;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            bit_cnt <= '0;
        end else if (sync) begin
            bit_cnt <= en ? CW'(1) : '0;
        end else if (en) begin
            bit_cnt <= (bit_cnt == LAST) ? '0 : bit_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            asm_reg <= '0;
        end else if (en) begin
            asm_reg <= candidate;
        end
    end

    // A completing word loads even while the held word is being consumed,
    // so back-to-back words flow without a bubble.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            dout   <= '0;
            dvalid <= 1'b0;
        end else if (complete && hold_free) begin
            dout   <= candidate;
            dvalid <= 1'b1;
        end else if (dvalid && dready) begin
            dvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            overrun <= 1'b0;
        end else if (complete && !hold_free) begin
            overrun <= 1'b1;
        end else if (clr_ovr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_deserializer.sv
// Self-checking bench for serial_deserializer: fixed vector table, directed
// multi-cycle sequences and randomized traffic against a bit-queue model.
module tb_serial_deserializer;

    localparam int N = 8;

    logic         clk;
    logic         rstn;
    logic         si;
    logic         en;
    logic         sync;
    logic [N-1:0] dout;
    logic         dvalid;
    logic         dready;
    logic         overrun;
    logic         clr_ovr;
    logic [2:0]   bit_cnt;

    int checks = 0;
    int errors = 0;

    // Reference state: received bits of the partial word, plus output view.
    bit           m_bits[$];
    logic [N-1:0] m_dout;
    logic         m_dvalid;
    logic         m_ovr;

    typedef struct {
        logic         si;
        logic         en;
        logic         sync;
        logic         dready;
        logic         clr;
        logic         rstn;
        logic [N-1:0] exp_dout;
        logic         exp_dvalid;
        logic         exp_ovr;
        logic [2:0]   exp_cnt;
    } vec_t;

    vec_t tbl[11];

    serial_deserializer #(.n(N)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .si      (si),
        .en      (en),
        .sync    (sync),
        .dout    (dout),
        .dvalid  (dvalid),
        .dready  (dready),
        .overrun (overrun),
        .clr_ovr (clr_ovr),
        .bit_cnt (bit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic modelUpdate(input logic a_si, input logic a_en, input logic a_sync,
                               input logic a_dready, input logic a_clr, input logic a_rstn);
        logic         done;
        logic         free;
        logic [N-1:0] word;
        done = 1'b0;
        word = '0;
        if (!a_rstn) begin
            m_bits.delete();
            m_dout   = '0;
            m_dvalid = 1'b0;
            m_ovr    = 1'b0;
            return;
        end
        free = !m_dvalid || a_dready;
        if (a_sync) begin
            m_bits.delete();
            if (a_en) m_bits.push_back(a_si);
        end else if (a_en) begin
            m_bits.push_back(a_si);
            if (m_bits.size() == N) begin
                for (int i = 0; i < N; i++) word = word + (N'(m_bits[i]) << i);
                m_bits.delete();
                done = 1'b1;
            end
        end
        if (done && free) begin
            m_dout   = word;
            m_dvalid = 1'b1;
        end else if (m_dvalid && a_dready) begin
            m_dvalid = 1'b0;
        end
        if (done && !free) m_ovr = 1'b1;
        else if (a_clr)    m_ovr = 1'b0;
    endtask

    task automatic applyStimulus(input logic a_si, input logic a_en, input logic a_sync,
                                 input logic a_dready, input logic a_clr, input logic a_rstn);
        si      = a_si;
        en      = a_en;
        sync    = a_sync;
        dready  = a_dready;
        clr_ovr = a_clr;
        rstn    = a_rstn;
        @(posedge clk);
        modelUpdate(a_si, a_en, a_sync, a_dready, a_clr, a_rstn);
        #1;
    endtask

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, ".dout"},    32'(dout),    32'(m_dout));
        checkVal({tag, ".dvalid"},  32'(dvalid),  32'(m_dvalid));
        checkVal({tag, ".overrun"}, 32'(overrun), 32'(m_ovr));
        checkVal({tag, ".bit_cnt"}, 32'(bit_cnt), 32'(m_bits.size()));
    endtask

    task automatic sendWord(input logic [N-1:0] w, input logic rdy, input string tag);
        for (int i = 0; i < N; i++) begin
            applyStimulus(w[i], 1'b1, 1'b0, rdy, 1'b0, 1'b1);
            checkOutput(tag);
        end
    endtask

    initial begin
        si = 0; en = 0; sync = 0; dready = 0; clr_ovr = 0; rstn = 0;
        m_dout = '0; m_dvalid = 0; m_ovr = 0;

        // Reset, then 8'hA5 sent LSB first, then one idle consume cycle.
        //           si en sy rd cl rs  dout   dv ov cnt
        tbl[0]  = '{0, 0, 0, 1, 0, 0, 8'h00, 0, 0, 3'd0};
        tbl[1]  = '{1, 1, 0, 1, 0, 1, 8'h00, 0, 0, 3'd1};
        tbl[2]  = '{0, 1, 0, 1, 0, 1, 8'h00, 0, 0, 3'd2};
        tbl[3]  = '{1, 1, 0, 1, 0, 1, 8'h00, 0, 0, 3'd3};
        tbl[4]  = '{0, 1, 0, 1, 0, 1, 8'h00, 0, 0, 3'd4};
        tbl[5]  = '{0, 1, 0, 1, 0, 1, 8'h00, 0, 0, 3'd5};
        tbl[6]  = '{1, 1, 0, 1, 0, 1, 8'h00, 0, 0, 3'd6};
        tbl[7]  = '{0, 1, 0, 1, 0, 1, 8'h00, 0, 0, 3'd7};
        tbl[8]  = '{1, 1, 0, 1, 0, 1, 8'hA5, 1, 0, 3'd0};
        tbl[9]  = '{0, 0, 0, 1, 0, 1, 8'hA5, 0, 0, 3'd0};
        tbl[10] = '{1, 0, 0, 1, 0, 1, 8'hA5, 0, 0, 3'd0};

        for (int v = 0; v < 11; v++) begin
            applyStimulus(tbl[v].si, tbl[v].en, tbl[v].sync, tbl[v].dready, tbl[v].clr, tbl[v].rstn);
            checkVal($sformatf("tbl%0d.dout", v),    32'(dout),    32'(tbl[v].exp_dout));
            checkVal($sformatf("tbl%0d.dvalid", v),  32'(dvalid),  32'(tbl[v].exp_dvalid));
            checkVal($sformatf("tbl%0d.overrun", v), 32'(overrun), 32'(tbl[v].exp_ovr));
            checkVal($sformatf("tbl%0d.bit_cnt", v), 32'(bit_cnt), 32'(tbl[v].exp_cnt));
        end

        // Back-to-back words at full bit rate.
        sendWord(8'h3C, 1'b1, "b2b_3c");
        checkVal("b2b.first", 32'(dout), 32'h3C);
        checkVal("b2b.first_valid", 32'(dvalid), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        checkVal("b2b.gap_valid", 32'(dvalid), 32'd0);
        checkVal("b2b.gap_dout", 32'(dout), 32'h3C);
        for (int i = 1; i < N; i++) begin
            applyStimulus(N'(8'hC3) >> i & 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
            checkOutput("b2b_c3");
        end
        checkVal("b2b.second", 32'(dout), 32'hC3);
        checkVal("b2b.ovr", 32'(overrun), 32'd0);

        // Back-pressure: second word is dropped and overrun sets.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        sendWord(8'h11, 1'b0, "bp_11");
        sendWord(8'h22, 1'b0, "bp_22");
        checkVal("bp.dout", 32'(dout), 32'h11);
        checkVal("bp.dvalid", 32'(dvalid), 32'd1);
        checkVal("bp.ovr", 32'(overrun), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        checkVal("clr.ovr", 32'(overrun), 32'd0);
        checkVal("clr.dvalid", 32'(dvalid), 32'd0);
        checkOutput("clr");

        // Strobe toggling every cycle: bit_cnt must hold on en=0 cycles.
        for (int i = 0; i < 2 * N; i++) begin
            logic b;
            b = (i % 2 == 0) ? 1'(8'h5A >> (i / 2)) : 1'b1;
            applyStimulus(b, (i % 2 == 0), 1'b0, 1'b1, 1'b0, 1'b1);
            checkOutput("entog");
        end
        checkVal("entog.dout", 32'(dout), 32'h5A);

        // Realign after three junk bits.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        checkVal("sync.bit_cnt", 32'(bit_cnt), 32'd1);
        for (int i = 1; i < N; i++) begin
            applyStimulus(1'(8'h96 >> i), 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
            checkOutput("sync");
        end
        checkVal("sync.dout", 32'(dout), 32'h96);
        checkVal("sync.dvalid", 32'(dvalid), 32'd1);

        // Reset mid-word while a word is held.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        sendWord(8'hFF, 1'b0, "rst_ff");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        checkVal("rst.pre_cnt", 32'(bit_cnt), 32'd4);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkVal("rst.dout", 32'(dout), 32'h00);
        checkVal("rst.dvalid", 32'(dvalid), 32'd0);
        checkVal("rst.bit_cnt", 32'(bit_cnt), 32'd0);
        checkVal("rst.ovr", 32'(overrun), 32'd0);
        sendWord(8'h69, 1'b1, "rst_clean");
        checkVal("rst.clean", 32'(dout), 32'h69);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            applyStimulus(1'($urandom_range(0, 1)),
                          ($urandom_range(0, 9) < 7),
                          ($urandom_range(0, 31) == 0),
                          ($urandom_range(0, 1) == 1),
                          ($urandom_range(0, 15) == 0),
                          ($urandom_range(0, 199) != 0));
            checkOutput("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
